// File: rtl/mac_array_ctrl.sv
// Sequencer for a mac_tile array: kernel load, execute vectors, pipeline drain, done.
// Optional stall counter output (stall_cnt) is built when MAC_CTRL_PERF_CNT_EN is defined.
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_os,
  input  logic [cnt_bw-1:0] n_vec,
  input  logic              l0_empty,
  input  logic              ofifo_full,
  output logic              l0_rd,
  output logic [2*row-1:0]  inst_w,
  output logic              mode_select,
  output logic              ofifo_wr,
  output logic              busy,
  output logic              done
`ifdef MAC_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int LAT = row + col;
  localparam int DW  = $clog2(LAT + 1);
  localparam logic [cnt_bw-1:0] KLAST = cnt_bw'(col - 1);
  localparam logic [DW-1:0]     DLAST = DW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_KGAP,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [cnt_bw-1:0] kcnt_q;
  logic [cnt_bw-1:0] vcnt_q;
  logic [cnt_bw-1:0] nvec_q;
  logic [DW-1:0]     dcnt_q;
  logic              mode_q;
  logic              busy_q;
  logic              done_q;
  logic [LAT-1:0]    wr_sr_q;

  logic              issue;
  logic              exec_issue;
  logic [1:0]        base_inst_d;

  always_comb begin
    issue       = 1'b0;
    exec_issue  = 1'b0;
    base_inst_d = 2'b00;
    case (state_q)
      S_KLOAD: begin
        issue       = !l0_empty;
        base_inst_d = issue ? 2'b01 : 2'b00;
      end
      S_EXEC: begin
        issue       = !l0_empty && !ofifo_full;
        exec_issue  = issue;
        base_inst_d = issue ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
      vcnt_q  <= '0;
      nvec_q  <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_KLOAD;
            mode_q  <= mode_os;
            nvec_q  <= n_vec;
            kcnt_q  <= '0;
            vcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_KLOAD: begin
          if (issue) begin
            if (kcnt_q == KLAST) state_q <= S_KGAP;
            else                 kcnt_q  <= kcnt_q + cnt_bw'(1);
          end
        end
        S_KGAP: begin
          dcnt_q  <= '0;
          state_q <= (nvec_q == '0) ? S_DRAIN : S_EXEC;
        end
        S_EXEC: begin
          // Last issue leaves immediately so the drain window covers exactly LAT cycles.
          if (issue) begin
            if (vcnt_q == nvec_q - cnt_bw'(1)) state_q <= S_DRAIN;
            else                               vcnt_q  <= vcnt_q + cnt_bw'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DLAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Each execute issue reappears as an OFIFO write once it has crossed the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_sr_q <= '0;
    else        wr_sr_q <= {wr_sr_q[LAT-2:0], exec_issue};
  end

  for (genvar gi = 0; gi < row; gi++) begin : g_stagger
    logic [1:0] stage_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stage_q <= 2'b00;
        else        stage_q <= base_inst_d;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stage_q <= 2'b00;
        else        stage_q <= g_stagger[gi-1].stage_q;
      end
    end
    assign inst_w[2*gi +: 2] = stage_q;
  end

`ifdef MAC_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_KLOAD || state_q == S_EXEC) && !issue &&
                 stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign l0_rd       = issue;
  assign mode_select = mode_q;
  assign ofifo_wr    = wr_sr_q[LAT-1];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: per-cycle expected strobes plus per-run totals.
module tb_mac_array_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int BW  = 8;
  localparam int LAT = ROW + COL;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mode_os = 1'b0;
  logic [BW-1:0]     n_vec = '0;
  logic              l0_empty = 1'b0;
  logic              ofifo_full = 1'b0;
  logic              l0_rd;
  logic [2*ROW-1:0]  inst_w;
  logic              mode_select;
  logic              ofifo_wr;
  logic              busy;
  logic              done;
`ifdef MAC_CTRL_PERF_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  mac_array_ctrl #(.row(ROW), .col(COL), .cnt_bw(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode_os    (mode_os),
    .n_vec      (n_vec),
    .l0_empty   (l0_empty),
    .ofifo_full (ofifo_full),
    .l0_rd      (l0_rd),
    .inst_w     (inst_w),
    .mode_select(mode_select),
    .ofifo_wr   (ofifo_wr),
    .busy       (busy),
`ifdef MAC_CTRL_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int   loads;
    int   writes;
    int   length;
    logic mode;
  } run_exp_t;

  run_exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run(input string name, input logic mode, input logic [BW-1:0] nv,
                     input int e_lo, input int e_hi, input int f_lo, input int f_hi,
                     input int stalls, input int extra_start_c);
    logic [1:0]       base[$];
    int               wr_q[$];
    int               ph = 0;
    int               k = 0;
    int               v = 0;
    int               done_c = -1;
    int               loads = 0;
    int               writes = 0;
    int               c;
    logic             rd_e;
    logic [1:0]       inst_e;
    logic [2*ROW-1:0] vec_e;
    logic             wr_e;
    run_exp_t         ex;
    run_exp_t         got_ex;

    ex.loads  = COL;
    ex.writes = int'(nv);
    ex.length = COL + int'(nv) + LAT + 2 + stalls;
    ex.mode   = mode;
    sb_q.push_back(ex);

    @(negedge clk);
    start   = 1'b1;
    mode_os = mode;
    n_vec   = nv;
    base.push_back(2'b00);

    for (c = 1; c < 4000; c++) begin
      @(posedge clk);
      #1;
      // Scramble the run inputs after acceptance so latching is exercised.
      mode_os    = ~mode;
      n_vec      = nv + BW'(3);
      start      = (c == extra_start_c);
      l0_empty   = (c >= e_lo && c <= e_hi);
      ofifo_full = (c >= f_lo && c <= f_hi);
      @(negedge clk);

      for (int r = 0; r < ROW; r++)
        vec_e[2*r +: 2] = (c - 1 - r >= 0) ? base[c - 1 - r] : 2'b00;
      check_val({name, ":inst_w"}, 32'(inst_w), 32'(vec_e));

      wr_e = (wr_q.size() > 0 && wr_q[0] == c);
      if (wr_e) void'(wr_q.pop_front());
      check_val({name, ":ofifo_wr"}, 32'(ofifo_wr), 32'(wr_e));
      check_val({name, ":done"}, 32'(done), 32'(c == done_c));
      check_val({name, ":busy"}, 32'(busy), 32'(done_c < 0 || c <= done_c));
      check_val({name, ":mode_select"}, 32'(mode_select), 32'(mode));

      rd_e   = 1'b0;
      inst_e = 2'b00;
      case (ph)
        0: begin
          rd_e   = !l0_empty;
          inst_e = rd_e ? 2'b01 : 2'b00;
          if (rd_e) begin
            k++;
            if (k == COL) ph = 1;
          end
        end
        1: begin
          if (nv == 0) begin
            done_c = c + LAT + 1;
            ph = 3;
          end else begin
            ph = 2;
          end
        end
        2: begin
          rd_e   = !l0_empty && !ofifo_full;
          inst_e = rd_e ? 2'b10 : 2'b00;
          if (rd_e) begin
            wr_q.push_back(c + LAT);
            v++;
            if (v == int'(nv)) begin
              done_c = c + LAT + 1;
              ph = 3;
            end
          end
        end
        default: ;
      endcase
      base.push_back(inst_e);
      check_val({name, ":l0_rd"}, 32'(l0_rd), 32'(rd_e));

      if (inst_w[1:0] == 2'b01) loads++;
      if (ofifo_wr) writes++;

      if (done && sb_q.size() > 0) begin
        got_ex = sb_q.pop_front();
        check_val({name, ":n_loads"}, 32'(loads), 32'(got_ex.loads));
        check_val({name, ":n_writes"}, 32'(writes), 32'(got_ex.writes));
        check_val({name, ":run_len"}, 32'(c), 32'(got_ex.length));
        check_val({name, ":run_mode"}, 32'(mode_select), 32'(got_ex.mode));
`ifdef MAC_CTRL_PERF_CNT_EN
        check_val({name, ":stall_cnt"}, 32'(stall_cnt), 32'(stalls));
`endif
      end
      if (done_c > 0 && c >= done_c + 2) break;
    end
    check_val({name, ":finished_in_budget"}, 32'(c < 4000), 32'd1);
    check_val({name, ":sb_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    start = 1'b0;
    l0_empty = 1'b0;
    ofifo_full = 1'b0;
    $display("run %s mode=%0d n_vec=%0d loads=%0d writes=%0d done_cycle=%0d",
             name, mode, nv, loads, writes, done_c);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start   = 1'b1;
    mode_os = 1'b1;
    n_vec   = BW'(6);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check_val("rst_mid:in_exec", 32'(inst_w[1:0] == 2'b10 || l0_rd), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_mid:l0_rd", 32'(l0_rd), 32'd0);
    check_val("rst_mid:inst_w", 32'(inst_w), 32'd0);
    check_val("rst_mid:ofifo_wr", 32'(ofifo_wr), 32'd0);
    check_val("rst_mid:mode_select", 32'(mode_select), 32'd0);
    check_val("rst_mid:busy", 32'(busy), 32'd0);
    check_val("rst_mid:done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_val("rst_after:busy", 32'(busy), 32'd0);
      check_val("rst_after:done", 32'(done), 32'd0);
      check_val("rst_after:ofifo_wr", 32'(ofifo_wr), 32'd0);
    end
    $display("run reset_mid_exec: aborted in EXEC, idle afterwards");
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset:l0_rd", 32'(l0_rd), 32'd0);
    check_val("reset:inst_w", 32'(inst_w), 32'd0);
    check_val("reset:ofifo_wr", 32'(ofifo_wr), 32'd0);
    check_val("reset:mode_select", 32'(mode_select), 32'd0);
    check_val("reset:busy", 32'(busy), 32'd0);
    check_val("reset:done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run("basic",         1'b0, BW'(4),   -1, -1, -1, -1, 0, 0);
    run("kload_empty",   1'b1, BW'(4),    3,  5, -1, -1, 3, 0);
    run("exec_full",     1'b0, BW'(4),   -1, -1, 11, 12, 2, 0);
    run("both_stall",    1'b1, BW'(3),   11, 12, 11, 13, 3, 0);
    run("nvec_zero",     1'b0, BW'(0),   -1, -1, -1, -1, 0, 0);
    run("extra_start_os", 1'b1, BW'(5),  -1, -1, -1, -1, 0, 12);
    run("extra_start_ws", 1'b0, BW'(5),  -1, -1, -1, -1, 0, 12);
    run("nvec_max",      1'b1, BW'(255), -1, -1, 100, 101, 2, 0);
    reset_mid_run();
    run("post_reset",    1'b0, BW'(2),   -1, -1, -1, -1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
